// File: rtl/mem_exc_stage_if.sv
// EX->MEM->WB bundle for the MEM exception stage.
// The master side is EX/WB/CP0; the slave side is the MEM stage.
interface mem_exc_stage_if #(
  parameter int PC_W  = 32,
  parameter int EXC_W = 5
);
  logic             em_valid;
  logic             ms_allowin;
  logic [PC_W-1:0]  em_pc;
  logic             em_bd;
  logic             em_exc;
  logic [EXC_W-1:0] em_exccode;
  logic [PC_W-1:0]  em_badvaddr;
  logic             em_ov;
  logic             em_load;
  logic             em_store;
  logic [1:0]       em_size;
  logic [PC_W-1:0]  em_addr;
  logic             em_eret;
  logic             em_mtc0;
  logic             em_mfc0;
  logic [5:0]       em_cp0_addr;
  logic             ws_allowin;
  logic             flush;
  logic             data_req;
  logic             valid_r;
  logic             mem_to_wb_exception_r;
  logic             mem_to_wb_bd_r;
  logic             mem_to_wb_eret_r;
  logic             mem_to_wb_mtc0_op_r;
  logic [EXC_W-1:0] mem_to_wb_ExcCode_r;
  logic [PC_W-1:0]  mem_to_wb_PC_r;
  logic [PC_W-1:0]  error_VAddr;
  logic [5:0]       cp0_addr;

  modport master (
    output em_valid, em_pc, em_bd, em_exc, em_exccode, em_badvaddr, em_ov,
           em_load, em_store, em_size, em_addr, em_eret, em_mtc0, em_mfc0,
           em_cp0_addr, ws_allowin, flush,
    input  ms_allowin, data_req, valid_r, mem_to_wb_exception_r, mem_to_wb_bd_r,
           mem_to_wb_eret_r, mem_to_wb_mtc0_op_r, mem_to_wb_ExcCode_r,
           mem_to_wb_PC_r, error_VAddr, cp0_addr
  );

  modport slave (
    input  em_valid, em_pc, em_bd, em_exc, em_exccode, em_badvaddr, em_ov,
           em_load, em_store, em_size, em_addr, em_eret, em_mtc0, em_mfc0,
           em_cp0_addr, ws_allowin, flush,
    output ms_allowin, data_req, valid_r, mem_to_wb_exception_r, mem_to_wb_bd_r,
           mem_to_wb_eret_r, mem_to_wb_mtc0_op_r, mem_to_wb_ExcCode_r,
           mem_to_wb_PC_r, error_VAddr, cp0_addr
  );
endinterface

// File: rtl/mem_exc_stage.sv
// MEM stage: latches the EX bundle, detects alignment/overflow faults, merges them
// with upstream exceptions into one prioritized record and registers it for CP0 in WB.
module mem_exc_stage #(
  parameter int PC_W  = 32,
  parameter int EXC_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  mem_exc_stage_if.slave  bus
);
  localparam logic [EXC_W-1:0] EXC_OV   = EXC_W'(5'h0C);
  localparam logic [EXC_W-1:0] EXC_ADEL = EXC_W'(5'h04);
  localparam logic [EXC_W-1:0] EXC_ADES = EXC_W'(5'h05);

  logic             ms_valid_q;
  logic [PC_W-1:0]  ms_pc_q;
  logic             ms_bd_q;
  logic             ms_em_exc_q;
  logic [EXC_W-1:0] ms_exccode_q;
  logic [PC_W-1:0]  ms_badvaddr_q;
  logic             ms_ov_q;
  logic             ms_load_q;
  logic             ms_store_q;
  logic [1:0]       ms_size_q;
  logic [PC_W-1:0]  ms_addr_q;
  logic             ms_eret_q;
  logic             ms_mtc0_q;
  logic [5:0]       ms_cp0_addr_q;

  logic             wb_valid_q;
  logic             wb_exc_q;
  logic             wb_bd_q;
  logic             wb_eret_q;
  logic             wb_mtc0_q;
  logic [EXC_W-1:0] wb_exccode_q;
  logic [PC_W-1:0]  wb_pc_q;
  logic [PC_W-1:0]  wb_vaddr_q;
  logic [5:0]       wb_cp0_addr_q;

  logic             exc_d;
  logic [EXC_W-1:0] exccode_d;
  logic [PC_W-1:0]  vaddr_d;
  logic             misalign;
  logic             shadow;
  logic             ms_allowin;

  assign ms_allowin = !ms_valid_q || bus.ws_allowin;
  assign misalign   = (ms_size_q == 2'd1 && ms_addr_q[0]) ||
                      (ms_size_q >= 2'd2 && ms_addr_q[1:0] != 2'b00);
  // An excepting or eret instruction in WB blocks any younger memory access.
  assign shadow     = wb_valid_q && (wb_exc_q || wb_eret_q);

  always_comb begin
    exc_d     = 1'b0;
    exccode_d = '0;
    vaddr_d   = '0;
    if (ms_em_exc_q) begin
      exc_d     = 1'b1;
      exccode_d = ms_exccode_q;
      vaddr_d   = ms_badvaddr_q;
    end else if (ms_ov_q) begin
      exc_d     = 1'b1;
      exccode_d = EXC_OV;
    end else if (ms_load_q && misalign) begin
      exc_d     = 1'b1;
      exccode_d = EXC_ADEL;
      vaddr_d   = ms_addr_q;
    end else if (ms_store_q && misalign) begin
      exc_d     = 1'b1;
      exccode_d = EXC_ADES;
      vaddr_d   = ms_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ms_valid_q    <= 1'b0;
      ms_pc_q       <= '0;
      ms_bd_q       <= 1'b0;
      ms_em_exc_q   <= 1'b0;
      ms_exccode_q  <= '0;
      ms_badvaddr_q <= '0;
      ms_ov_q       <= 1'b0;
      ms_load_q     <= 1'b0;
      ms_store_q    <= 1'b0;
      ms_size_q     <= '0;
      ms_addr_q     <= '0;
      ms_eret_q     <= 1'b0;
      ms_mtc0_q     <= 1'b0;
      ms_cp0_addr_q <= '0;
      wb_valid_q    <= 1'b0;
      wb_exc_q      <= 1'b0;
      wb_bd_q       <= 1'b0;
      wb_eret_q     <= 1'b0;
      wb_mtc0_q     <= 1'b0;
      wb_exccode_q  <= '0;
      wb_pc_q       <= '0;
      wb_vaddr_q    <= '0;
      wb_cp0_addr_q <= '0;
    end else begin
      if (bus.flush)       ms_valid_q <= 1'b0;
      else if (ms_allowin) ms_valid_q <= bus.em_valid;

      if (bus.em_valid && ms_allowin && !bus.flush) begin
        ms_pc_q       <= bus.em_pc;
        ms_bd_q       <= bus.em_bd;
        ms_em_exc_q   <= bus.em_exc;
        ms_exccode_q  <= bus.em_exccode;
        ms_badvaddr_q <= bus.em_badvaddr;
        ms_ov_q       <= bus.em_ov;
        ms_load_q     <= bus.em_load;
        ms_store_q    <= bus.em_store;
        ms_size_q     <= bus.em_size;
        ms_addr_q     <= bus.em_addr;
        ms_eret_q     <= bus.em_eret;
        ms_mtc0_q     <= bus.em_mtc0;
        ms_cp0_addr_q <= bus.em_cp0_addr;
      end

      if (bus.flush)           wb_valid_q <= 1'b0;
      else if (bus.ws_allowin) wb_valid_q <= ms_valid_q;

      // Payload may go stale across a flush; WB qualifies it with valid_r.
      if (bus.ws_allowin) begin
        wb_exc_q      <= exc_d;
        wb_bd_q       <= ms_bd_q;
        wb_eret_q     <= ms_eret_q && !exc_d;
        wb_mtc0_q     <= ms_mtc0_q && !exc_d;
        wb_exccode_q  <= exccode_d;
        wb_pc_q       <= ms_pc_q;
        wb_vaddr_q    <= vaddr_d;
        wb_cp0_addr_q <= ms_cp0_addr_q;
      end
    end
  end

  assign bus.ms_allowin            = ms_allowin;
  assign bus.data_req              = ms_valid_q && (ms_load_q || ms_store_q) && !exc_d &&
                                     !shadow && !bus.flush;
  assign bus.valid_r               = wb_valid_q;
  assign bus.mem_to_wb_exception_r = wb_exc_q;
  assign bus.mem_to_wb_bd_r        = wb_bd_q;
  assign bus.mem_to_wb_eret_r      = wb_eret_q;
  assign bus.mem_to_wb_mtc0_op_r   = wb_mtc0_q;
  assign bus.mem_to_wb_ExcCode_r   = wb_exccode_q;
  assign bus.mem_to_wb_PC_r        = wb_pc_q;
  assign bus.error_VAddr           = wb_vaddr_q;
  assign bus.cp0_addr              = wb_cp0_addr_q;
endmodule

// File: tb/tb_mem_exc_stage.sv
// Directed bench for mem_exc_stage: one task per scenario, hand-computed expectations.
module tb_mem_exc_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_exc_stage_if bus ();
  mem_exc_stage dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.em_valid = 0; bus.em_pc = '0; bus.em_bd = 0; bus.em_exc = 0;
    bus.em_exccode = '0; bus.em_badvaddr = '0; bus.em_ov = 0; bus.em_load = 0;
    bus.em_store = 0; bus.em_size = 2'd2; bus.em_addr = '0; bus.em_eret = 0;
    bus.em_mtc0 = 0; bus.em_mfc0 = 0; bus.em_cp0_addr = '0;
    bus.ws_allowin = 1; bus.flush = 0;
  endtask

  task automatic send_mem(input logic [31:0] pc, input logic ld, input logic st,
                          input logic [1:0] size, input logic [31:0] addr);
    idle();
    bus.em_valid = 1; bus.em_pc = pc; bus.em_load = ld; bus.em_store = st;
    bus.em_size = size; bus.em_addr = addr;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick(); tick();
    checks++; if (bus.ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%0b exp=1", bus.ms_allowin); end
    checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL reset_data_req got=%0b exp=0", bus.data_req); end
    checks++; if (bus.valid_r !== 1'b0) begin errors++; $display("FAIL reset_valid_r got=%0b exp=0", bus.valid_r); end
    checks++; if (bus.mem_to_wb_PC_r !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.mem_to_wb_PC_r); end
    rst = 0;
    $display("test_reset done");
  endtask

  task automatic test_aligned_load();
    send_mem(32'hBFC0_0100, 1, 0, 2'd2, 32'h8000_0004);
    tick(); idle();
    checks++; if (bus.data_req !== 1'b1) begin errors++; $display("FAIL aligned_data_req got=%0b exp=1", bus.data_req); end
    tick();
    checks++; if (bus.valid_r !== 1'b1) begin errors++; $display("FAIL aligned_valid got=%0b exp=1", bus.valid_r); end
    checks++; if (bus.mem_to_wb_exception_r !== 1'b0) begin errors++; $display("FAIL aligned_exc got=%0b exp=0", bus.mem_to_wb_exception_r); end
    checks++; if (bus.mem_to_wb_ExcCode_r !== 5'h00) begin errors++; $display("FAIL aligned_code got=%h exp=00", bus.mem_to_wb_ExcCode_r); end
    checks++; if (bus.mem_to_wb_PC_r !== 32'hBFC0_0100) begin errors++; $display("FAIL aligned_pc got=%h exp=bfc00100", bus.mem_to_wb_PC_r); end
    $display("test_aligned_load pc=%h", bus.mem_to_wb_PC_r);
  endtask

  task automatic test_misaligned_load();
    send_mem(32'hBFC0_0200, 1, 0, 2'd1, 32'h8000_0003);
    tick(); idle();
    checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL lh_data_req got=%0b exp=0", bus.data_req); end
    tick();
    checks++; if (bus.mem_to_wb_exception_r !== 1'b1) begin errors++; $display("FAIL lh_exc got=%0b exp=1", bus.mem_to_wb_exception_r); end
    checks++; if (bus.mem_to_wb_ExcCode_r !== 5'h04) begin errors++; $display("FAIL lh_code got=%h exp=04", bus.mem_to_wb_ExcCode_r); end
    checks++; if (bus.error_VAddr !== 32'h8000_0003) begin errors++; $display("FAIL lh_vaddr got=%h exp=80000003", bus.error_VAddr); end
    $display("test_misaligned_load code=%h", bus.mem_to_wb_ExcCode_r);
  endtask

  task automatic test_priority();
    // Misaligned store alone -> AdES
    send_mem(32'hBFC0_0300, 0, 1, 2'd2, 32'h8000_0012);
    tick(); idle(); tick();
    checks++; if (bus.mem_to_wb_ExcCode_r !== 5'h05) begin errors++; $display("FAIL ades_code got=%h exp=05", bus.mem_to_wb_ExcCode_r); end
    checks++; if (bus.error_VAddr !== 32'h8000_0012) begin errors++; $display("FAIL ades_vaddr got=%h exp=80000012", bus.error_VAddr); end
    // Overflow beats AdES
    send_mem(32'hBFC0_0304, 0, 1, 2'd2, 32'h8000_0012);
    bus.em_ov = 1;
    tick(); idle(); tick();
    checks++; if (bus.mem_to_wb_ExcCode_r !== 5'h0C) begin errors++; $display("FAIL ov_code got=%h exp=0c", bus.mem_to_wb_ExcCode_r); end
    checks++; if (bus.error_VAddr !== 32'h0) begin errors++; $display("FAIL ov_vaddr got=%h exp=0", bus.error_VAddr); end
    // Upstream exception beats overflow
    send_mem(32'hBFC0_0308, 0, 1, 2'd2, 32'h8000_0012);
    bus.em_ov = 1; bus.em_exc = 1; bus.em_exccode = 5'h04; bus.em_badvaddr = 32'hBFC0_0001;
    tick(); idle(); tick();
    checks++; if (bus.mem_to_wb_ExcCode_r !== 5'h04) begin errors++; $display("FAIL upstream_code got=%h exp=04", bus.mem_to_wb_ExcCode_r); end
    checks++; if (bus.error_VAddr !== 32'hBFC0_0001) begin errors++; $display("FAIL upstream_vaddr got=%h exp=bfc00001", bus.error_VAddr); end
    // Size 3 is treated as a word
    send_mem(32'hBFC0_030C, 1, 0, 2'd3, 32'h8000_0002);
    tick(); idle(); tick();
    checks++; if (bus.mem_to_wb_ExcCode_r !== 5'h04) begin errors++; $display("FAIL size3_code got=%h exp=04", bus.mem_to_wb_ExcCode_r); end
    $display("test_priority code=%h", bus.mem_to_wb_ExcCode_r);
  endtask

  task automatic test_shadow_flush();
    send_mem(32'hBFC0_0400, 1, 0, 2'd2, 32'h8000_0001);   // AdEL
    tick();
    send_mem(32'hBFC0_0404, 1, 0, 2'd2, 32'h8000_0008);   // younger aligned lw
    tick(); idle();
    checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL shadow_data_req got=%0b exp=0", bus.data_req); end
    send_mem(32'hBFC0_0408, 1, 0, 2'd2, 32'h8000_000C);   // discarded by flush
    bus.flush = 1;
    #1;
    checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL flush_data_req got=%0b exp=0", bus.data_req); end
    tick(); idle();
    bus.ws_allowin = 0;
    #1;
    checks++; if (bus.ms_allowin !== 1'b1) begin errors++; $display("FAIL flush_ms_empty got=%0b exp=1", bus.ms_allowin); end
    checks++; if (bus.valid_r !== 1'b0) begin errors++; $display("FAIL flush_valid_r got=%0b exp=0", bus.valid_r); end
    bus.ws_allowin = 1;
    $display("test_shadow_flush valid_r=%0b", bus.valid_r);
  endtask

  task automatic test_back_pressure();
    send_mem(32'hBFC0_0500, 1, 0, 2'd2, 32'h8000_0020);
    tick();
    send_mem(32'hBFC0_0504, 0, 1, 2'd2, 32'h8000_0024);
    tick(); idle();
    bus.ws_allowin = 0;
    #1;
    checks++; if (bus.data_req !== 1'b1) begin errors++; $display("FAIL bp_data_req got=%0b exp=1", bus.data_req); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.ms_allowin !== 1'b0) begin errors++; $display("FAIL bp_allowin_%0d got=%0b exp=0", i, bus.ms_allowin); end
      checks++; if (bus.mem_to_wb_PC_r !== 32'hBFC0_0500) begin errors++; $display("FAIL bp_hold_pc_%0d got=%h exp=bfc00500", i, bus.mem_to_wb_PC_r); end
      tick();
    end
    bus.ws_allowin = 1;
    tick();
    checks++; if (bus.mem_to_wb_PC_r !== 32'hBFC0_0504) begin errors++; $display("FAIL bp_release_pc got=%h exp=bfc00504", bus.mem_to_wb_PC_r); end
    checks++; if (bus.valid_r !== 1'b1) begin errors++; $display("FAIL bp_release_valid got=%0b exp=1", bus.valid_r); end
    $display("test_back_pressure pc=%h", bus.mem_to_wb_PC_r);
  endtask

  task automatic test_eret_mtc0();
    idle();
    bus.em_valid = 1; bus.em_pc = 32'hBFC0_0600; bus.em_eret = 1;
    bus.em_exc = 1; bus.em_exccode = 5'h0A;
    tick(); idle(); tick();
    checks++; if (bus.mem_to_wb_eret_r !== 1'b0) begin errors++; $display("FAIL eret_exc_eret got=%0b exp=0", bus.mem_to_wb_eret_r); end
    checks++; if (bus.mem_to_wb_exception_r !== 1'b1) begin errors++; $display("FAIL eret_exc_exc got=%0b exp=1", bus.mem_to_wb_exception_r); end
    checks++; if (bus.mem_to_wb_ExcCode_r !== 5'h0A) begin errors++; $display("FAIL eret_exc_code got=%h exp=0a", bus.mem_to_wb_ExcCode_r); end
    idle();
    bus.em_valid = 1; bus.em_pc = 32'hBFC0_0604; bus.em_eret = 1;
    tick(); idle(); tick();
    checks++; if (bus.mem_to_wb_eret_r !== 1'b1) begin errors++; $display("FAIL eret_clean got=%0b exp=1", bus.mem_to_wb_eret_r); end
    idle();
    bus.em_valid = 1; bus.em_pc = 32'hBFC0_0608; bus.em_mtc0 = 1; bus.em_bd = 1; bus.em_cp0_addr = 6'h18;
    tick(); idle(); tick();
    checks++; if (bus.mem_to_wb_mtc0_op_r !== 1'b1) begin errors++; $display("FAIL mtc0_op got=%0b exp=1", bus.mem_to_wb_mtc0_op_r); end
    checks++; if (bus.cp0_addr !== 6'h18) begin errors++; $display("FAIL mtc0_addr got=%h exp=18", bus.cp0_addr); end
    checks++; if (bus.mem_to_wb_bd_r !== 1'b1) begin errors++; $display("FAIL mtc0_bd got=%0b exp=1", bus.mem_to_wb_bd_r); end
    idle();
    bus.em_valid = 1; bus.em_mtc0 = 1; bus.em_ov = 1;
    tick(); idle(); tick();
    checks++; if (bus.mem_to_wb_mtc0_op_r !== 1'b0) begin errors++; $display("FAIL mtc0_exc got=%0b exp=0", bus.mem_to_wb_mtc0_op_r); end
    $display("test_eret_mtc0 cp0_addr=%h", bus.cp0_addr);
  endtask

  task automatic test_reset_midstream();
    send_mem(32'hBFC0_0700, 1, 0, 2'd2, 32'h8000_0030);
    tick();
    send_mem(32'hBFC0_0704, 1, 0, 2'd2, 32'h8000_0034);
    rst = 1; bus.flush = 1;
    tick(); idle();
    checks++; if (bus.ms_allowin !== 1'b1) begin errors++; $display("FAIL rst_mid_allowin got=%0b exp=1", bus.ms_allowin); end
    checks++; if (bus.valid_r !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%0b exp=0", bus.valid_r); end
    checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL rst_mid_data_req got=%0b exp=0", bus.data_req); end
    checks++; if (bus.mem_to_wb_PC_r !== 32'h0) begin errors++; $display("FAIL rst_mid_pc got=%h exp=0", bus.mem_to_wb_PC_r); end
    checks++; if (bus.cp0_addr !== 6'h0) begin errors++; $display("FAIL rst_mid_cp0 got=%h exp=0", bus.cp0_addr); end
    rst = 0;
    $display("test_reset_midstream valid_r=%0b", bus.valid_r);
  endtask

  initial begin
    idle();
    test_reset();
    test_aligned_load();
    test_misaligned_load();
    test_priority();
    test_shadow_flush();
    test_back_pressure();
    test_eret_mtc0();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_exc_stage.md
# mem_exc_stage

MEM pipeline stage of the MIPS core: latches the EX→MEM bundle, performs the data-address alignment check and the ALU-overflow check, and merges these with exceptions already flagged upstream (fetch AdEL, RI, Sys, Bp) into one prioritized exception record. It drives the registered `mem_to_wb_*` bundle consumed by the CP0 in WB. It also suppresses data-memory requests behind any exception or eret, and flushes itself on the CP0 `ClrStpJmp` pulse.

## Interface
- `PC_W`, 32, width of PC and address fields
- `EXC_W`, 5, width of ExcCode
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `em_valid` in 1: EX→MEM bundle valid
- `ms_allowin` out 1: MEM accepts the bundle this cycle
- `em_pc` in 32 / `em_bd` in 1: PC; instruction is in a delay slot
- `em_exc` in 1 / `em_exccode` in 5 / `em_badvaddr` in 32: upstream exception, its code, and its faulting address
- `em_ov` in 1: ALU signed overflow (already gated by instruction type)
- `em_load` / `em_store` in 1: memory op kind
- `em_size` in 2: 0 byte, 1 half, 2 word (3 illegal, treated as word)
- `em_addr` in 32: effective data address
- `em_eret` / `em_mtc0` / `em_mfc0` in 1: CP0 op flags
- `em_cp0_addr` in 6: {rd, sel}
- `ws_allowin` in 1: WB accepts the bundle
- `flush` in 1: CP0 `ClrStpJmp`
- `data_req` out 1: data-SRAM request enable for the instruction in MEM
- `valid_r`, `mem_to_wb_exception_r`, `mem_to_wb_bd_r`, `mem_to_wb_eret_r`, `mem_to_wb_mtc0_op_r` out 1: registered WB bundle
- `mem_to_wb_ExcCode_r` out 5; `mem_to_wb_PC_r`, `error_VAddr` out 32; `cp0_addr` out 6

## Operation
- **Stage register (`ms_*`)**: loads all `em_*` fields when `em_valid && ms_allowin`. `ms_valid <= em_valid` whenever `ms_allowin`.
- **Handshake**: `ms_ready_go = 1`; `ms_allowin = !ms_valid || ws_allowin`.
- **Alignment**: `misalign = (size==1 && addr[0]) || (size>=2 && addr[1:0]!=0)`.
- **Exception priority** (first match wins):
  1. `ms_em_exc`: code `ms_exccode`, vaddr `ms_badvaddr`
  2. `ms_ov`: code 0x0C, vaddr 0
  3. load && misalign: AdEL 0x04, vaddr `ms_addr`
  4. store && misalign: AdES 0x05, vaddr `ms_addr`
- If none match, exception = 0, code = 0, vaddr = 0.
- **Exception shadow**: `shadow = valid_r && (mem_to_wb_exception_r || mem_to_wb_eret_r)`.
- `data_req = ms_valid && (load||store) && !ms_exc && !shadow && !flush`.
- **WB register**: when `ws_allowin`, `valid_r <= ms_valid`. On the same condition, the remaining fields load from the MEM computation.
  - `mem_to_wb_eret_r` and `mem_to_wb_mtc0_op_r` are forced to 0 when the exception bit is 1.
- **Flush** (`flush=1`): next cycle `ms_valid=0` and `valid_r=0`, overriding any simultaneous load. Payload fields may hold stale data, and consumers qualify them with `valid_r`.
- **mfc0**: carried only as `cp0_addr`; the read data path is outside this block.

## Timing
- Latency: 1 cycle EX→MEM register, 1 cycle MEM→WB register.
  - `mem_to_wb_*` is visible to CP0 on the 2nd edge after `em_valid` is accepted, provided `ws_allowin` stays high.
- **Reset**: all outputs are 0, except `ms_allowin` (1 in the first cycle after reset).
  - `ms_valid=0`; all stage registers are 0.
- **Back-pressure**: with `ws_allowin=0` and `ms_valid=1`, `ms_*` and `mem_to_wb_*` hold and `ms_allowin=0`. `data_req` stays asserted while holding (the request is idempotent per cycle).
- **Flush with `em_valid` in the same cycle**: the incoming bundle is discarded.
- **Reset with `flush`**: reset wins; the result is identical.
- **Shadow**: `shadow` is combinational from registered state. A younger load in MEM never issues while an excepting or eret instruction sits in WB, and is removed by the `flush` that follows.
- Back-to-back accepts every cycle are sustained when `ws_allowin=1`.

## Test plan
- **Aligned load**: lw, `addr=0x8000_0004`, no errors → `data_req=1` in MEM. Two cycles later `valid_r=1`, `exception=0`, `ExcCode=0`, PC passed through.
- **Misaligned halfword load**: lh, `addr=0x8000_0003` → `data_req=0`, `exception=1`, `ExcCode=0x04`, `error_VAddr=0x8000_0003`.
- **Priority**: sw with `addr[1:0]=2` plus `em_ov=1` → `ExcCode=0x0C`. Adding `em_exc=1`, `em_exccode=0x04`, `em_badvaddr=0xBFC0_0001` → `ExcCode=0x04`, `error_VAddr=0xBFC0_0001`.
- **Shadow and flush**: excepting instruction in WB with `flush=1`, younger lw in MEM → `data_req=0`. Next cycle `ms_valid=0` and `valid_r=0`.
- **Back-pressure**: `ws_allowin=0` for 3 cycles with a bundle in MEM → `ms_allowin=0` and `mem_to_wb_*` unchanged. On release, the bundle appears in the WB register the next cycle.
- **eret / mtc0 with exception, and reset mid-stream**:
  - eret with `em_exc=1`, `em_exccode=0x0A` → `eret_r=0`, `exception=1`, `ExcCode=0x0A`.
  - `rst=1` mid-stream → all outputs 0 and `ms_allowin=1` in the next cycle.
